problem2_sweep_ctrl: RTL and testbench

Self-checking sweep controller for the `problem2` combinational block (A, B, C → AB, AC, X). On a start pulse it drives all eight input combinations in ascending order {A,B,C} = 000…111. For each vector it waits a programmable settle time, samples the three outputs and compares them against the reference function AB = A&B, AC = A&C, X = AB|AC. It sits beside the `problem2` instance as its on-chip exerciser and reports pass/fail plus a mismatch count.

---
 rtl/problem2_pkg.sv | 20 ++
 rtl/problem2_ref_model.sv | 18 +
 rtl/problem2_sweep_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_problem2_sweep_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/problem2_pkg.sv
// Shared types and constants for the problem2 sweep controller.
// Optional logging ports are enabled with the PROBLEM2_SWEEP_LOG_EN macro.
package problem2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int unsigned NUM_VECS = 8;

  // Expected {x,ab,ac} for input vector {a,b,c} = index
  localparam logic [2:0] EXP_TBL [0:7] = '{
    3'b000, 3'b000, 3'b000, 3'b000,
    3'b000, 3'b101, 3'b110, 3'b111
  };

endpackage

// File: rtl/problem2_ref_model.sv
// Functional reference for problem2: AB = A&B, AC = A&C, X = AB|AC.
// Output is packed as {x,ab,ac}; input is {a,b,c} with A as MSB.
module problem2_ref_model (
  input  logic [2:0] abc_i,
  output logic [2:0] exp_o
);

  logic ab;
  logic ac;

  // Evaluate the reference equations for the driven vector
  always_comb begin
    ab    = abc_i[2] & abc_i[1];
    ac    = abc_i[2] & abc_i[0];
    exp_o = {ab | ac, ab, ac};
  end

endmodule

// File: rtl/problem2_sweep_ctrl.sv
// On-chip exerciser for problem2: walks {a,b,c} through 000..111, waits
// SETTLE_CYCLES+1 cycles per vector, then compares the block outputs against
// the reference and counts mismatching vectors.
// Macro PROBLEM2_SWEEP_LOG_EN adds first-failure capture ports.
module problem2_sweep_ctrl
  import problem2_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          USE_EXP_TBL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       x_in,
  input  logic       ab_in,
  input  logic       ac_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] vec_idx
`ifdef PROBLEM2_SWEEP_LOG_EN
  ,
  output logic       first_fail_vld,
  output logic [2:0] first_fail_vec,
  output logic [2:0] first_fail_obs
`endif
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [2:0] LAST_VEC  = 3'(NUM_VECS - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;

  logic [2:0] exp_vec;
  logic [2:0] obs_vec;
  logic       mismatch;

`ifdef PROBLEM2_SWEEP_LOG_EN
  logic       ff_vld_q, ff_vld_d;
  logic [2:0] ff_vec_q, ff_vec_d;
  logic [2:0] ff_obs_q, ff_obs_d;
`endif

  // Exactly one expected-value source is built: table lookup or functional model
  generate
    if (USE_EXP_TBL) begin : g_tbl
      assign exp_vec = EXP_TBL[vec_q];
    end else begin : g_ref
      problem2_ref_model u_ref (
        .abc_i (vec_q),
        .exp_o (exp_vec)
      );
    end
  endgenerate

  assign obs_vec  = {x_in, ab_in, ac_in};
  assign mismatch = (obs_vec != exp_vec);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_WAIT;
      ST_WAIT:   if (cnt_q == '0) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (vec_q == LAST_VEC) ? ST_DONE : ST_WAIT;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: settle counter, vector index, error bookkeeping
  always_comb begin
    cnt_d  = cnt_q;
    vec_d  = vec_q;
    err_d  = err_q;
    pass_d = pass_q;
    busy_d = busy_q;
`ifdef PROBLEM2_SWEEP_LOG_EN
    ff_vld_d = ff_vld_q;
    ff_vec_d = ff_vec_q;
    ff_obs_d = ff_obs_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d  = '0;
          cnt_d  = SETTLE_LD;
          err_d  = '0;
          pass_d = 1'b0;
          busy_d = 1'b1;
`ifdef PROBLEM2_SWEEP_LOG_EN
          ff_vld_d = 1'b0;
          ff_vec_d = '0;
          ff_obs_d = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
`ifdef PROBLEM2_SWEEP_LOG_EN
          if (!ff_vld_q) begin
            ff_vld_d = 1'b1;
            ff_vec_d = vec_q;
            ff_obs_d = obs_vec;
          end
`endif
        end
        if (vec_q != LAST_VEC) begin
          vec_d = vec_q + 3'd1;
          cnt_d = SETTLE_LD;
        end
      end
      ST_DONE: begin
        pass_d = (err_q == '0);
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      vec_q  <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef PROBLEM2_SWEEP_LOG_EN
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
      ff_obs_q <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      vec_q  <= vec_d;
      err_q  <= err_d;
      pass_q <= pass_d;
      busy_q <= busy_d;
`ifdef PROBLEM2_SWEEP_LOG_EN
      ff_vld_q <= ff_vld_d;
      ff_vec_q <= ff_vec_d;
      ff_obs_q <= ff_obs_d;
`endif
    end
  end

  // Output decode: drive bits follow the vector index, done marks the DONE state
  always_comb begin
    {a, b, c} = vec_q;
    vec_idx   = vec_q;
    busy      = busy_q;
    done      = (state_q == ST_DONE);
    pass      = pass_q;
    err_cnt   = err_q;
`ifdef PROBLEM2_SWEEP_LOG_EN
    first_fail_vld = ff_vld_q;
    first_fail_vec = ff_vec_q;
    first_fail_obs = ff_obs_q;
`endif
  end

endmodule

// File: tb/tb_problem2_sweep_ctrl.sv
// Directed bench for problem2_sweep_ctrl: two instances (SETTLE_CYCLES 2 and 0)
// each driving a behavioural problem2 with optional stuck-at faults.
module tb_problem2_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] start_r;
  logic [1:0] a_w, b_w, c_w;
  logic [1:0] x_w, ab_w, ac_w;
  logic [1:0] busy_w, done_w, pass_w;
  logic [3:0] err_w [2];
  logic [2:0] vec_w [2];
  logic       x_stuck0;
  logic       ab_stuck1;
`ifdef PROBLEM2_SWEEP_LOG_EN
  logic [1:0] ffv_w;
  logic [2:0] ffvec_w [2];
  logic [2:0] ffobs_w [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural problem2 blocks with fault injection
  assign x_w[0]  = x_stuck0  ? 1'b0 : ((a_w[0] & b_w[0]) | (a_w[0] & c_w[0]));
  assign ab_w[0] = ab_stuck1 ? 1'b1 : (a_w[0] & b_w[0]);
  assign ac_w[0] = a_w[0] & c_w[0];
  assign x_w[1]  = x_stuck0  ? 1'b0 : ((a_w[1] & b_w[1]) | (a_w[1] & c_w[1]));
  assign ab_w[1] = ab_stuck1 ? 1'b1 : (a_w[1] & b_w[1]);
  assign ac_w[1] = a_w[1] & c_w[1];

  problem2_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_r[0]),
    .a       (a_w[0]),
    .b       (b_w[0]),
    .c       (c_w[0]),
    .x_in    (x_w[0]),
    .ab_in   (ab_w[0]),
    .ac_in   (ac_w[0]),
    .busy    (busy_w[0]),
    .done    (done_w[0]),
    .pass    (pass_w[0]),
    .err_cnt (err_w[0]),
    .vec_idx (vec_w[0])
`ifdef PROBLEM2_SWEEP_LOG_EN
    ,
    .first_fail_vld (ffv_w[0]),
    .first_fail_vec (ffvec_w[0]),
    .first_fail_obs (ffobs_w[0])
`endif
  );

  problem2_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_r[1]),
    .a       (a_w[1]),
    .b       (b_w[1]),
    .c       (c_w[1]),
    .x_in    (x_w[1]),
    .ab_in   (ab_w[1]),
    .ac_in   (ac_w[1]),
    .busy    (busy_w[1]),
    .done    (done_w[1]),
    .pass    (pass_w[1]),
    .err_cnt (err_w[1]),
    .vec_idx (vec_w[1])
`ifdef PROBLEM2_SWEEP_LOG_EN
    ,
    .first_fail_vld (ffv_w[1]),
    .first_fail_vec (ffvec_w[1]),
    .first_fail_obs (ffobs_w[1])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; runs one sweep on instance sel with N = n cycles per vector
  task automatic run_sweep(input int sel, input int n, input logic [3:0] exp_err,
                           input logic exp_pass, input int restart_at);
    start_r[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r[sel] = 1'b0;
    chk("e0_busy", 8'(busy_w[sel]), 8'd1);
    chk("e0_vec", 8'(vec_w[sel]), 8'd0);
    chk("e0_err", 8'(err_w[sel]), 8'd0);
    chk("e0_pass", 8'(pass_w[sel]), 8'd0);
    for (int e = 1; e <= 8 * n + 3; e++) begin
      start_r[sel] = (e == restart_at);
      @(posedge clk);
      @(negedge clk);
      if (e < 8 * n) begin
        chk("vec", 8'(vec_w[sel]), 8'(e / n));
        chk("abc", 8'({a_w[sel], b_w[sel], c_w[sel]}), 8'(e / n));
        chk("done_lo", 8'(done_w[sel]), 8'd0);
        chk("busy_hi", 8'(busy_w[sel]), 8'd1);
      end else if (e == 8 * n) begin
        chk("done_hi", 8'(done_w[sel]), 8'd1);
        chk("busy_done", 8'(busy_w[sel]), 8'd1);
        chk("vec_last", 8'(vec_w[sel]), 8'd7);
      end else begin
        chk("done_after", 8'(done_w[sel]), 8'd0);
        chk("busy_after", 8'(busy_w[sel]), 8'd0);
        chk("err_cnt", 8'(err_w[sel]), 8'(exp_err));
        chk("pass", 8'(pass_w[sel]), 8'(exp_pass));
      end
    end
    start_r[sel] = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start_r   = '0;
    x_stuck0  = 1'b0;
    ab_stuck1 = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 8'(busy_w[i]), 8'd0);
      chk("rst_done", 8'(done_w[i]), 8'd0);
      chk("rst_pass", 8'(pass_w[i]), 8'd0);
      chk("rst_err", 8'(err_w[i]), 8'd0);
      chk("rst_vec", 8'(vec_w[i]), 8'd0);
      chk("rst_abc", 8'({a_w[i], b_w[i], c_w[i]}), 8'd0);
`ifdef PROBLEM2_SWEEP_LOG_EN
      chk("rst_ffv", 8'(ffv_w[i]), 8'd0);
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Clean sweep, SETTLE_CYCLES=2
    run_sweep(0, 4, 4'd0, 1'b1, -1);
    // Extra start 10 cycles in is ignored; also clears the previous pass at E0
    run_sweep(0, 4, 4'd0, 1'b1, 10);
    // x stuck at 0: vectors 101, 110, 111 fail
    x_stuck0 = 1'b1;
    run_sweep(0, 4, 4'd3, 1'b0, -1);
    x_stuck0 = 1'b0;

    // Reset asserted mid-sweep at cycle 15
    start_r[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_rst_busy", 8'(busy_w[0]), 8'd1);
    chk("pre_rst_vec", 8'(vec_w[0]), 8'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 8'(busy_w[0]), 8'd0);
    chk("arst_vec", 8'(vec_w[0]), 8'd0);
    chk("arst_abc", 8'({a_w[0], b_w[0], c_w[0]}), 8'd0);
    chk("arst_err", 8'(err_w[0]), 8'd0);
    chk("arst_pass", 8'(pass_w[0]), 8'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_done", 8'(done_w[0]), 8'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_done", 8'(done_w[0]), 8'd0);
    end
    run_sweep(0, 4, 4'd0, 1'b1, -1);

    // SETTLE_CYCLES=0 instance
    run_sweep(1, 2, 4'd0, 1'b1, -1);

`ifdef PROBLEM2_SWEEP_LOG_EN
    // ab stuck at 1: vectors 000..101 fail, first at 000 observing 010
    ab_stuck1 = 1'b1;
    run_sweep(0, 4, 4'd6, 1'b0, -1);
    ab_stuck1 = 1'b0;
    chk("ff_vld", 8'(ffv_w[0]), 8'd1);
    chk("ff_vec", 8'(ffvec_w[0]), 8'd0);
    chk("ff_obs", 8'(ffobs_w[0]), 8'h2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
